adder_share_arb: RTL and testbench
==================================

// Module: adder_share_arb
// PURPOSE
//   Shares one W-bit adder (rca or any pipelined adder variant, latency PIPE) among N
//   requesters. Round-robin arbiter; registered operand issue; per-request tag pipeline
//   that routes each sum/carry back to its requester. Sits between client blocks
//   (multiplier partial-product stages, accumulators) and a single adder instance.
// PARAMETERS
//   W     32  operand / sum width
//   N     4   number of requesters (2..16)
//   PIPE  0   register stages inside the attached adder (0 = combinational)
// PORTS
//   clk        in   1      clock
//   rst        in   1      synchronous reset, active-high
//   en         in   1      grant enable; 0 = no new grants, in-flight ops still complete
//   req_valid  in   N      request valid, one bit per requester
//   req_ready  out  N      one-hot grant (zero or one bit set)
//   req_a      in   N*W    operand a, requester i at [i*W +: W]
//   req_b      in   N*W    operand b, same packing
//   req_cin    in   N      carry-in per requester
//   add_a      out  W      to adder a (registered)
//   add_b      out  W      to adder b (registered)
//   add_cin    out  1      to adder c_in (registered)
//   add_s      in   W      from adder s
//   add_cout   in   1      from adder c_out
//   rsp_valid  out  N      one-hot response strobe, one cycle, no backpressure
//   rsp_s      out  W      sum, broadcast; valid only when rsp_valid != 0
//   rsp_cout   out  1      carry-out, broadcast
//   busy       out  1      any operation in flight (issue reg or tag pipe)
//   issue_cnt  out  16     total handshakes since reset, wraps 0xFFFF -> 0
// BEHAVIOUR
//   Reset: ptr=0, add_a/add_b=0, add_cin=0, tag pipe cleared, rsp_valid=0, busy=0,
//     issue_cnt=0. req_ready=0 while rst=1. Reset mid-operation discards in-flight ops;
//     no rsp_valid for them afterwards.
//   Arbitration (combinational): if en, scan i = ptr, ptr+1, ... mod N; first i with
//     req_valid[i]=1 gets req_ready[i]=1. req_ready depends on req_valid (valid must not
//     depend on ready). Handshake = req_valid[i] & req_ready[i].
//   Pointer: on handshake by i, ptr <= (i+1) mod N; no handshake -> ptr unchanged.
//   Issue: on a handshake at edge t, add_a/add_b/add_cin <= granted operands, issue tag
//     <= {1, i}. No handshake -> operand regs <= 0, tag valid <= 0 (idle zeros).
//   Tag pipe: PIPE stages behind issue tag, shifts every cycle (adder cannot stall).
//   Response: in the cycle the tag reaches stage PIPE, rsp_valid[tag]=1,
//     rsp_s=add_s, rsp_cout=add_cout (combinational passthrough). Otherwise
//     rsp_valid=0; rsp_s/rsp_cout=0.
//   Latency: handshake edge t -> response visible in cycle t+1+PIPE.
//     PIPE=0 -> response in the cycle after the handshake.
//   Throughput: one issue per cycle; back-to-back grants allowed, including the same
//     requester when it is the only one valid.
//   Ordering: responses are returned in issue order; a requester may have up to PIPE+1
//     ops outstanding.
//   en=0: no new grants; tag pipe drains normally; ptr held.
//   busy = tag valid in any issue/pipe stage.
//   issue_cnt increments by 1 per handshake, modulo 2^16.
//   Arithmetic is not done here: sum/carry come from the adder unmodified, including
//     wrap-around (0xFFFFFFFF+1 -> s=0, cout=1 with W=32).
// TESTING (N=4, W=32; run with PIPE=0 and PIPE=2)
//   1. Single req: req 2 with a=0x00000005, b=0x00000003, cin=0 -> req_ready=4'b0100;
//      rsp_valid=4'b0100 exactly 1+PIPE cycles later; rsp_s=0x00000008, cout=0.
//   2. All 4 valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//      Responses follow the same order; issue_cnt=8.
//   3. Carry/wrap: a=0xFFFFFFFF, b=0x00000000, cin=1 -> rsp_s=0x00000000, rsp_cout=1.
//   4. en=0 with req 1 valid for 3 cycles -> req_ready=0, no grants.
//      In-flight op still responds; busy falls to 0 after drain.
//   5. rst=1 one cycle after 2 issues (PIPE=2) -> no rsp_valid after reset.
//      busy=0, issue_cnt=0, ptr=0 (next grant favors req 0 when all valid).
//   6. issue_cnt preloaded via 65535 single-req handshakes, then 1 more -> issue_cnt=0.
//      Every response sum matches a+b+cin from a reference model.

Source files
------------

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// adder_share_arb : round-robin sharing of one W-bit adder among N requesters,
//                   with a tag pipeline that routes each result back.
// Revision        : 1.0
// ============================================================================
module adder_share_arb #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int PIPE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N-1:0]   req_cin,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_cin,
  input  logic [W-1:0]   add_s,
  input  logic           add_cout,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_s,
  output logic           rsp_cout,
  output logic           busy,
  output logic [15:0]    issue_cnt
);

  localparam int c_ID_W  = (N > 1) ? $clog2(N) : 1;
  localparam int c_TAG_W = c_ID_W + 1;

  logic [c_ID_W-1:0]              r_ptr;
  logic [W-1:0]                   r_add_a;
  logic [W-1:0]                   r_add_b;
  logic                           r_add_cin;
  logic [15:0]                    r_cnt;
  logic [PIPE:0][c_TAG_W-1:0]     r_tag;

  logic [N-1:0]                   w_grant;
  logic [c_ID_W-1:0]              w_gid;
  logic [c_ID_W-1:0]              w_cand;
  logic                           w_hs;
  int                             w_idx;
  logic [W-1:0]                   w_a;
  logic [W-1:0]                   w_b;
  logic                           w_cin;
  logic [c_TAG_W-1:0]             w_new_tag;
  logic [c_TAG_W-1:0]             w_out_tag;
  logic                           w_busy;

  // Scan from the farthest candidate back to ptr so the closest valid one wins.
  always_comb begin
    w_grant = '0;
    w_gid   = '0;
    w_cand  = '0;
    w_hs    = 1'b0;
    w_idx   = 0;
    if (en && !rst) begin
      for (int k = N - 1; k >= 0; k--) begin
        w_idx = int'(r_ptr) + k;
        if (w_idx >= N) begin
          w_idx = w_idx - N;
        end
        w_cand = c_ID_W'(w_idx);
        if (req_valid[w_cand]) begin
          w_hs  = 1'b1;
          w_gid = w_cand;
        end
      end
      if (w_hs) begin
        w_grant[w_gid] = 1'b1;
      end
    end
  end

  assign req_ready = w_grant;
  assign w_a       = req_a[w_gid*W +: W];
  assign w_b       = req_b[w_gid*W +: W];
  assign w_cin     = req_cin[w_gid];
  assign w_new_tag = {w_hs, w_gid};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_add_a   <= w_hs ? w_a : '0;
      r_add_b   <= w_hs ? w_b : '0;
      r_add_cin <= w_hs & w_cin;
      if (w_hs) begin
        r_ptr <= (w_gid == c_ID_W'(N - 1)) ? '0 : w_gid + 1'b1;
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Stage 0 is the issue tag; it then tracks the adder's internal registers.
  generate
    if (PIPE > 0) begin : g_tag_pipe
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tag <= '0;
        end else begin
          r_tag <= {r_tag[PIPE-1:0], w_new_tag};
        end
      end
    end else begin : g_tag_issue
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tag <= '0;
        end else begin
          r_tag <= w_new_tag;
        end
      end
    end
  endgenerate

  always_comb begin
    w_busy = 1'b0;
    for (int s = 0; s <= PIPE; s++) begin
      w_busy = w_busy | r_tag[s][c_TAG_W-1];
    end
  end

  assign w_out_tag = r_tag[PIPE];

  always_comb begin
    rsp_valid = '0;
    rsp_s     = '0;
    rsp_cout  = 1'b0;
    if (w_out_tag[c_TAG_W-1]) begin
      rsp_valid[w_out_tag[c_ID_W-1:0]] = 1'b1;
      rsp_s                            = add_s;
      rsp_cout                         = add_cout;
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;
  assign busy      = w_busy;
  assign issue_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
// ============================================================================
// tb_adder_share_arb : drives two arbiters (PIPE=0 and PIPE=2) with the same
//                      requests, each attached to its own behavioural adder.
// Revision           : 1.0
// ============================================================================
module tb_adder_share_arb;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;

  logic [N-1:0] ready0, ready2, rv0, rv2;
  logic [W-1:0] aa0, ab0, as0, rs0, aa2, ab2, as2, rs2;
  logic         ac0, aco0, rc0, busy0, ac2, aco2, rc2, busy2;
  logic [15:0]  cnt0, cnt2;
  logic [W:0]   p2a, p2b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    logic [N-1:0] oh;
    logic [W:0] sum;
  } exp_t;
  exp_t q0[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_share_arb #(.W(W), .N(N), .PIPE(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(ready0),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(aa0), .add_b(ab0), .add_cin(ac0), .add_s(as0), .add_cout(aco0),
    .rsp_valid(rv0), .rsp_s(rs0), .rsp_cout(rc0), .busy(busy0), .issue_cnt(cnt0)
  );

  adder_share_arb #(.W(W), .N(N), .PIPE(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(ready2),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(aa2), .add_b(ab2), .add_cin(ac2), .add_s(as2), .add_cout(aco2),
    .rsp_valid(rv2), .rsp_s(rs2), .rsp_cout(rc2), .busy(busy2), .issue_cnt(cnt2)
  );

  // Attached adders: one combinational, one with two register stages.
  assign {aco0, as0} = {1'b0, aa0} + {1'b0, ab0} + {{W{1'b0}}, ac0};
  always @(posedge clk) begin
    p2a <= {1'b0, aa2} + {1'b0, ab2} + {{W{1'b0}}, ac2};
    p2b <= p2a;
  end
  assign {aco2, as2} = p2b;

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a   = (N*W)'(a) << (i*W);
    req_b   = (N*W)'(b) << (i*W);
    req_cin = N'(c) << i;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a = (req_a << W) | (N*W)'($urandom());
      req_b = (req_b << W) | (N*W)'($urandom());
    end
    req_cin = N'($urandom());
  endtask

  function automatic logic [W:0] ref_sum(input int g);
    logic [W-1:0] ta, tb;
    logic         tc;
    ta = W'(req_a >> (g*W));
    tb = W'(req_b >> (g*W));
    tc = |((req_cin >> g) & N'(1));
    return {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q2.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; req_valid = '1;
    #1;
    checks++; if (ready0 !== 4'b0000) begin failures++; $display("FAIL reset_ready0 got=%b exp=0000", ready0); end
    checks++; if (ready2 !== 4'b0000) begin failures++; $display("FAIL reset_ready2 got=%b exp=0000", ready2); end
    @(negedge clk);
    #1;
    checks++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", busy0, busy2); end
    checks++; if (cnt0 !== 16'd0 || cnt2 !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%h/%h exp=0", cnt0, cnt2); end
    checks++; if (rv0 !== 4'b0 || rv2 !== 4'b0) begin failures++; $display("FAIL reset_rsp got=%b/%b exp=0", rv0, rv2); end
    checks++; if (aa2 !== '0 || ab0 !== '0 || ac0 !== 1'b0) begin failures++; $display("FAIL reset_ops got=%h/%h/%b exp=0", aa2, ab0, ac0); end
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    @(negedge clk);
    en = 1'b1;
    set_op(2, 32'h5, 32'h3, 1'b0);
    req_valid = 4'b0100;
    #1;
    checks++; if (ready0 !== 4'b0100) begin failures++; $display("FAIL single_ready0 got=%b exp=0100", ready0); end
    checks++; if (ready2 !== 4'b0100) begin failures++; $display("FAIL single_ready2 got=%b exp=0100", ready2); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (k == 1) begin
        checks++; if (rv0 !== 4'b0100 || rs0 !== 32'h8 || rc0 !== 1'b0) begin failures++; $display("FAIL single_rsp0 got=%b/%h/%b exp=0100/8/0", rv0, rs0, rc0); end
      end else begin
        checks++; if (rv0 !== 4'b0) begin failures++; $display("FAIL single_idle0 k=%0d got=%b exp=0000", k, rv0); end
      end
      if (k == 3) begin
        checks++; if (rv2 !== 4'b0100 || rs2 !== 32'h8 || rc2 !== 1'b0) begin failures++; $display("FAIL single_rsp2 got=%b/%h/%b exp=0100/8/0", rv2, rs2, rc2); end
      end else begin
        checks++; if (rv2 !== 4'b0 || busy2 !== 1'b1) begin failures++; $display("FAIL single_wait2 k=%0d got=%b busy=%b exp=0000 busy=1", k, rv2, busy2); end
      end
    end
    checks++; if (cnt0 !== 16'd1 || cnt2 !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d/%0d exp=1", cnt0, cnt2); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    set_op(0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    req_valid = 4'b0001;
    #1;
    checks++; if (ready0 !== 4'b0001) begin failures++; $display("FAIL wrap_ready got=%b exp=0001", ready0); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (k == 1) begin
        checks++; if (rv0 !== 4'b0001 || rs0 !== 32'h0 || rc0 !== 1'b1) begin failures++; $display("FAIL wrap_rsp0 got=%b/%h/%b exp=0001/0/1", rv0, rs0, rc0); end
      end
      if (k == 3) begin
        checks++; if (rv2 !== 4'b0001 || rs2 !== 32'h0 || rc2 !== 1'b1) begin failures++; $display("FAIL wrap_rsp2 got=%b/%h/%b exp=0001/0/1", rv2, rs2, rc2); end
      end
    end
  endtask

  task automatic test_en_off();
    @(negedge clk);
    en = 1'b1;
    set_op(1, 32'd10, 32'd20, 1'b1);
    req_valid = 4'b0010;
    #1;
    checks++; if (ready0 !== 4'b0010) begin failures++; $display("FAIL en_first_ready got=%b exp=0010", ready0); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      en = 1'b0;
      req_valid = (k <= 3) ? 4'b0010 : 4'b0000;
      #1;
      checks++; if (ready0 !== 4'b0 || ready2 !== 4'b0) begin failures++; $display("FAIL en_off_ready k=%0d got=%b/%b exp=0000", k, ready0, ready2); end
      if (k == 1) begin
        checks++; if (rv0 !== 4'b0010 || rs0 !== 32'd31) begin failures++; $display("FAIL en_off_rsp0 got=%b/%h exp=0010/1f", rv0, rs0); end
      end
      if (k == 2) begin
        checks++; if (busy0 !== 1'b0 || busy2 !== 1'b1) begin failures++; $display("FAIL en_off_busy got=%b/%b exp=0/1", busy0, busy2); end
      end
      if (k == 3) begin
        checks++; if (rv2 !== 4'b0010 || rs2 !== 32'd31) begin failures++; $display("FAIL en_off_rsp2 got=%b/%h exp=0010/1f", rv2, rs2); end
      end
      if (k == 4) begin
        checks++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL en_off_drain got=%b/%b exp=0/0", busy0, busy2); end
        checks++; if (cnt0 !== 16'd3 || cnt2 !== 16'd3) begin failures++; $display("FAIL en_off_cnt got=%0d/%0d exp=3", cnt0, cnt2); end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_round_robin();
    int           got0, got2;
    logic [N-1:0] exp_g;
    logic [W:0]   sum;
    do_reset();
    got0 = 0;
    got2 = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      rand_ops();
      en = 1'b1;
      req_valid = (k < 8) ? '1 : '0;
      #1;
      if (k < 8) begin
        exp_g = N'(1) << (k % N);
        checks++; if (ready0 !== exp_g || ready2 !== exp_g) begin failures++; $display("FAIL rr_grant k=%0d got=%b/%b exp=%b", k, ready0, ready2, exp_g); end
        sum = ref_sum(k % N);
        q0.push_back('{cyc + 1, exp_g, sum});
        q2.push_back('{cyc + 3, exp_g, sum});
      end
      if (q0.size() > 0 && q0[0].due == cyc) begin
        checks++; if (rv0 !== q0[0].oh || {rc0, rs0} !== q0[0].sum) begin failures++; $display("FAIL rr_rsp0 got=%b/%h exp=%b/%h", rv0, {rc0, rs0}, q0[0].oh, q0[0].sum); end
        void'(q0.pop_front());
        got0++;
      end else begin
        checks++; if (rv0 !== '0) begin failures++; $display("FAIL rr_idle0 got=%b exp=0000", rv0); end
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
        checks++; if (rv2 !== q2[0].oh || {rc2, rs2} !== q2[0].sum) begin failures++; $display("FAIL rr_rsp2 got=%b/%h exp=%b/%h", rv2, {rc2, rs2}, q2[0].oh, q2[0].sum); end
        void'(q2.pop_front());
        got2++;
      end else begin
        checks++; if (rv2 !== '0) begin failures++; $display("FAIL rr_idle2 got=%b exp=0000", rv2); end
      end
    end
    checks++; if (got0 != 8 || got2 != 8) begin failures++; $display("FAIL rr_count got=%0d/%0d exp=8", got0, got2); end
    checks++; if (cnt0 !== 16'd8 || cnt2 !== 16'd8) begin failures++; $display("FAIL rr_issue_cnt got=%0d/%0d exp=8", cnt0, cnt2); end
  endtask

  task automatic test_reset_mid();
    logic [W:0] sum;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      en = 1'b1;
      rand_ops();
      req_valid = '1;
      #1;
      checks++; if (ready2 !== (N'(1) << k)) begin failures++; $display("FAIL rmid_issue k=%0d got=%b", k, ready2); end
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rand_ops();
    req_valid = '1;
    #1;
    sum = ref_sum(0);
    checks++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b/%b exp=0/0", busy0, busy2); end
    checks++; if (cnt0 !== 16'd0 || cnt2 !== 16'd0) begin failures++; $display("FAIL rmid_cnt got=%0d/%0d exp=0", cnt0, cnt2); end
    checks++; if (rv0 !== '0 || rv2 !== '0) begin failures++; $display("FAIL rmid_rsp got=%b/%b exp=0000", rv0, rv2); end
    checks++; if (ready0 !== 4'b0001 || ready2 !== 4'b0001) begin failures++; $display("FAIL rmid_ptr got=%b/%b exp=0001", ready0, ready2); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (k == 1) begin
        checks++; if (rv0 !== 4'b0001 || {rc0, rs0} !== sum) begin failures++; $display("FAIL rmid_rsp0 got=%b/%h exp=0001/%h", rv0, {rc0, rs0}, sum); end
      end
      if (k == 3) begin
        checks++; if (rv2 !== 4'b0001 || {rc2, rs2} !== sum) begin failures++; $display("FAIL rmid_rsp2 got=%b/%h exp=0001/%h", rv2, {rc2, rs2}, sum); end
      end else begin
        checks++; if (rv2 !== '0) begin failures++; $display("FAIL rmid_stale k=%0d got=%b exp=0000", k, rv2); end
      end
    end
  endtask

  task automatic test_random_count();
    int           hs_total, iter, mptr, g, idx;
    logic [15:0]  mcnt;
    logic [N-1:0] v, exp_g;
    logic [W:0]   sum;
    do_reset();
    mptr = 0;
    mcnt = '0;
    hs_total = 0;
    iter = 0;
    while (hs_total < 65536 && iter < 90000) begin
      iter++;
      @(negedge clk);
      rand_ops();
      if ($urandom_range(0, 1) == 0) v = N'(1) << $urandom_range(0, N - 1);
      else v = N'($urandom_range(0, (1 << N) - 1));
      req_valid = v;
      en = ($urandom_range(0, 31) != 0);
      #1;
      g = -1;
      if (en) begin
        for (int k = 0; k < N; k++) begin
          idx = (mptr + k) % N;
          if (g < 0 && ((v >> idx) & N'(1)) != '0) g = idx;
        end
      end
      exp_g = (g >= 0) ? (N'(1) << g) : '0;
      checks++; if (ready0 !== exp_g || ready2 !== exp_g) begin failures++; $display("FAIL rnd_grant got=%b/%b exp=%b", ready0, ready2, exp_g); end
      checks++; if (cnt0 !== mcnt || cnt2 !== mcnt) begin failures++; $display("FAIL rnd_cnt got=%h/%h exp=%h", cnt0, cnt2, mcnt); end
      checks++; if (busy0 !== (q0.size() != 0) || busy2 !== (q2.size() != 0)) begin failures++; $display("FAIL rnd_busy got=%b/%b exp=%b/%b", busy0, busy2, q0.size() != 0, q2.size() != 0); end
      if (q0.size() > 0 && q0[0].due == cyc) begin
        checks++; if (rv0 !== q0[0].oh || {rc0, rs0} !== q0[0].sum) begin failures++; $display("FAIL rnd_rsp0 got=%b/%h exp=%b/%h", rv0, {rc0, rs0}, q0[0].oh, q0[0].sum); end
        void'(q0.pop_front());
      end else begin
        checks++; if (rv0 !== '0 || rs0 !== '0) begin failures++; $display("FAIL rnd_idle0 got=%b/%h exp=0", rv0, rs0); end
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
        checks++; if (rv2 !== q2[0].oh || {rc2, rs2} !== q2[0].sum) begin failures++; $display("FAIL rnd_rsp2 got=%b/%h exp=%b/%h", rv2, {rc2, rs2}, q2[0].oh, q2[0].sum); end
        void'(q2.pop_front());
      end else begin
        checks++; if (rv2 !== '0 || rs2 !== '0) begin failures++; $display("FAIL rnd_idle2 got=%b/%h exp=0", rv2, rs2); end
      end
      if (g >= 0) begin
        sum = ref_sum(g);
        q0.push_back('{cyc + 1, exp_g, sum});
        q2.push_back('{cyc + 3, exp_g, sum});
        mptr = (g + 1) % N;
        mcnt = mcnt + 16'd1;
        hs_total++;
      end
    end
    checks++; if (hs_total != 65536) begin failures++; $display("FAIL rnd_budget got=%0d exp=65536", hs_total); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (cnt0 !== 16'h0000 || cnt2 !== 16'h0000) begin failures++; $display("FAIL rnd_wrap got=%h/%h exp=0000", cnt0, cnt2); end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    test_reset();
    test_single();
    test_wrap();
    test_en_off();
    test_round_robin();
    test_reset_mid();
    test_random_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
